// File: rtl/rope_scorer.sv
// rope_scorer: tug-of-war rope position, round flash, scoring and match-winner logic
module rope_scorer #(
  parameter int FLASH_TICKS   = 8,
  parameter int WINS_TO_MATCH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pl,
  input  logic       pr,
  input  logic       slowen,
  output logic [6:0] leds,
  output logic [1:0] score_l,
  output logic [1:0] score_r,
  output logic       win_l,
  output logic       win_r,
  output logic       round_done,
  output logic       tie
);
  localparam logic [1:0] PLAY   = 2'd0;
  localparam logic [1:0] RWIN_L = 2'd1;
  localparam logic [1:0] RWIN_R = 2'd2;
  localparam logic [1:0] MATCH  = 2'd3;
  localparam logic [6:0] PAT_L  = 7'b1110000;
  localparam logic [6:0] PAT_R  = 7'b0000111;
  localparam logic [1:0] WINS   = 2'(WINS_TO_MATCH);
  localparam logic [3:0] LAST   = 4'(FLASH_TICKS - 1);
  logic [1:0] state, state_n, sl_n, sr_n;
  logic [2:0] pos, pos_n;
  logic [3:0] ticks, ticks_n;
  logic       lit, lit_n, rd_n, tie_n, win_l_n, win_r_n;
  logic [6:0] leds_n;
  // next-state: rope movement in PLAY, flash timing in RWIN_x, MATCH is terminal
  always_comb begin
    state_n = state;
    pos_n   = pos;
    sl_n    = score_l;
    sr_n    = score_r;
    ticks_n = ticks;
    lit_n   = lit;
    rd_n    = 1'b0;
    tie_n   = 1'b0;
    case (state)
      PLAY:
        if (pl && pr) tie_n = 1'b1;
        else if (pl) begin
          if (pos == 3'd6) begin
            state_n = RWIN_L;
            sl_n    = score_l < WINS ? score_l + 2'd1 : score_l;
            rd_n    = 1'b1;
            lit_n   = 1'b1;
            ticks_n = 4'd0;
          end else pos_n = pos + 3'd1;
        end else if (pr) begin
          if (pos == 3'd0) begin
            state_n = RWIN_R;
            sr_n    = score_r < WINS ? score_r + 2'd1 : score_r;
            rd_n    = 1'b1;
            lit_n   = 1'b1;
            ticks_n = 4'd0;
          end else pos_n = pos - 3'd1;
        end
      RWIN_L, RWIN_R:
        if (slowen) begin
          if (ticks == LAST) begin
            ticks_n = 4'd0;
            if ((state == RWIN_L ? score_l : score_r) == WINS) state_n = MATCH;
            else begin
              state_n = PLAY;
              pos_n   = 3'd3;
            end
          end else begin
            ticks_n = ticks + 4'd1;
            lit_n   = !lit;
          end
        end
      default: ;
    endcase
  end
  // winner flags latch on entry to MATCH; leds are derived from the next state so they stay registered
  always_comb begin
    win_l_n = win_l | (state == RWIN_L && state_n == MATCH);
    win_r_n = win_r | (state == RWIN_R && state_n == MATCH);
    leds_n  = state_n == PLAY   ? 7'd1 << pos_n :
              state_n == RWIN_L ? (lit_n ? PAT_L : 7'd0) :
              state_n == RWIN_R ? (lit_n ? PAT_R : 7'd0) :
              win_l_n ? PAT_L : PAT_R;
  end
  // all state and outputs registered with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PLAY;
      pos        <= 3'd3;
      ticks      <= 4'd0;
      lit        <= 1'b0;
      leds       <= 7'b0001000;
      score_l    <= 2'd0;
      score_r    <= 2'd0;
      win_l      <= 1'b0;
      win_r      <= 1'b0;
      round_done <= 1'b0;
      tie        <= 1'b0;
    end else begin
      state      <= state_n;
      pos        <= pos_n;
      ticks      <= ticks_n;
      lit        <= lit_n;
      leds       <= leds_n;
      score_l    <= sl_n;
      score_r    <= sr_n;
      win_l      <= win_l_n;
      win_r      <= win_r_n;
      round_done <= rd_n;
      tie        <= tie_n;
    end
  end
endmodule

// File: tb/tb_rope_scorer.sv
// tb_rope_scorer: directed and random checks of rope_scorer against a behavioural game model
module tb_rope_scorer;
  localparam int FT = 8;
  localparam int W  = 2;
  localparam logic [6:0] PL = 7'b1110000;
  localparam logic [6:0] PR = 7'b0000111;
  logic clk = 1'b0, rst = 1'b0, pl = 1'b0, pr = 1'b0, slowen = 1'b0;
  logic [6:0] leds;
  logic [1:0] score_l, score_r;
  logic win_l, win_r, round_done, tie;
  logic [14:0] obs;
  int vectors = 0, miscompares = 0;
  // model: mode 0 play, 1 left flash, 2 right flash, 3 match over
  int m_pos = 3, m_sl = 0, m_sr = 0, m_mode = 0, m_ticks = 0, m_winner = 0;
  bit m_rd = 0, m_tie = 0;
  rope_scorer #(.FLASH_TICKS(FT), .WINS_TO_MATCH(W)) dut (
    .clk(clk), .rst(rst), .pl(pl), .pr(pr), .slowen(slowen), .leds(leds),
    .score_l(score_l), .score_r(score_r), .win_l(win_l), .win_r(win_r),
    .round_done(round_done), .tie(tie)
  );
  assign obs = {leds, score_l, score_r, win_l, win_r, round_done, tie};
  always #5 clk = ~clk;
  function automatic logic [14:0] exp_vec();
    logic [6:0] l;
    if (m_mode == 0) l = 7'(1 << m_pos);
    else if (m_mode == 3) l = m_winner == 1 ? PL : PR;
    else l = (m_ticks % 2 == 0) ? (m_mode == 1 ? PL : PR) : 7'd0;
    return {l, 2'(m_sl), 2'(m_sr), m_mode == 3 && m_winner == 1, m_mode == 3 && m_winner == 2, m_rd, m_tie};
  endfunction
  task automatic step(input logic r, input logic a, input logic b, input logic s);
    rst = r; pl = a; pr = b; slowen = s;
    @(posedge clk);
    m_rd = 0; m_tie = 0;
    if (r) begin
      m_pos = 3; m_sl = 0; m_sr = 0; m_mode = 0; m_ticks = 0; m_winner = 0;
    end else if (m_mode == 0) begin
      if (a && b) m_tie = 1;
      else if (a && m_pos == 6) begin m_sl = m_sl < W ? m_sl + 1 : m_sl; m_mode = 1; m_ticks = 0; m_rd = 1; end
      else if (a) m_pos++;
      else if (b && m_pos == 0) begin m_sr = m_sr < W ? m_sr + 1 : m_sr; m_mode = 2; m_ticks = 0; m_rd = 1; end
      else if (b) m_pos--;
    end else if (m_mode != 3 && s) begin
      m_ticks++;
      if (m_ticks == FT) begin
        m_ticks = 0;
        if ((m_mode == 1 ? m_sl : m_sr) == W) begin m_winner = m_mode; m_mode = 3; end
        else begin m_mode = 0; m_pos = 3; end
      end
    end
    #1;
  endtask
  task automatic flash_out();
    for (int i = 0; i < FT; i++) begin
      step(0, 1, i[0], 1);
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL flash tick %0d: got %h want %h", i, obs, exp_vec()); end
      step(0, 0, 0, 0);
    end
  endtask
  task automatic test_reset();
    step(1, 1, 1, 1);
    vectors++;
    if (leds !== 7'b0001000 || obs !== exp_vec()) begin miscompares++; $display("FAIL reset: got %h want %h", obs, exp_vec()); end
  endtask
  task automatic test_walk();
    logic [6:0] want [3] = '{7'b0010000, 7'b0100000, 7'b1000000};
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      vectors++;
      if (leds !== want[i] || obs !== exp_vec()) begin miscompares++; $display("FAIL walk %0d: got leds %b want %b", i, leds, want[i]); end
      step(0, 0, 0, 0);
    end
  endtask
  task automatic test_round_left();
    step(0, 1, 0, 1);
    vectors++;
    if (score_l !== 2'd1 || round_done !== 1'b1 || leds !== PL) begin miscompares++; $display("FAIL round_left win: got %h want %h", obs, exp_vec()); end
    step(0, 0, 0, 0);
    vectors++;
    if (round_done !== 1'b0 || obs !== exp_vec()) begin miscompares++; $display("FAIL round_left pulse: got %h want %h", obs, exp_vec()); end
    flash_out();
    vectors++;
    if (leds !== 7'b0001000 || obs !== exp_vec()) begin miscompares++; $display("FAIL round_left exit: got leds %b want 0001000", leds); end
  endtask
  task automatic test_tie();
    step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    vectors++;
    if (leds !== 7'b0001000 || tie !== 1'b1 || score_l !== 0 || score_r !== 0) begin miscompares++; $display("FAIL tie: got %h want %h", obs, exp_vec()); end
    step(0, 0, 0, 0);
    vectors++;
    if (tie !== 1'b0 || obs !== exp_vec()) begin miscompares++; $display("FAIL tie end: got %h want %h", obs, exp_vec()); end
  endtask
  task automatic win_right_match();
    step(1, 0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
      flash_out();
    end
  endtask
  task automatic test_match_right();
    win_right_match();
    vectors++;
    if (score_r !== 2'd2 || win_r !== 1'b1 || win_l !== 1'b0 || leds !== PR) begin miscompares++; $display("FAIL match_right: got %h want %h", obs, exp_vec()); end
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], i[1], i[2]);
      vectors++;
      if (obs !== {PR, 2'd0, 2'd2, 4'b0100}) begin miscompares++; $display("FAIL match hold %0d: got %h", i, obs); end
    end
  endtask
  task automatic test_held();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0);
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL held %0d: got %h want %h", i, obs, exp_vec()); end
    end
    vectors++;
    if (score_l !== 2'd1 || m_mode != 1) begin miscompares++; $display("FAIL held score: got %0d want 1", score_l); end
  endtask
  task automatic test_reset_mid();
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 1, 0, 1);
    vectors++;
    if (obs !== {7'b0001000, 8'd0}) begin miscompares++; $display("FAIL reset mid-flash: got %h want %h", obs, {7'b0001000, 8'd0}); end
    win_right_match();
    step(1, 0, 1, 1);
    vectors++;
    if (obs !== {7'b0001000, 8'd0}) begin miscompares++; $display("FAIL reset in match: got %h want %h", obs, {7'b0001000, 8'd0}); end
    step(0, 1, 0, 0);
    vectors++;
    if (leds !== 7'b0010000) begin miscompares++; $display("FAIL first pull after reset: got %b want 0010000", leds); end
  endtask
  task automatic test_random();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
      vectors++;
      if (obs !== exp_vec()) begin miscompares++; $display("FAIL random cycle %0d: got %h want %h", i, obs, exp_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_walk();
    test_round_left();
    test_tie();
    test_match_right();
    test_held();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rope_scorer.md
ROPE_SCORER -- requirements
Module: rope_scorer

Interface
REQ-001 Parameter: FLASH_TICKS, default 8, number of slowen ticks the round-win flash lasts.
REQ-002 Parameter: WINS_TO_MATCH, default 2, round wins needed to take the match (1..3).
REQ-003 Port: clk  input  1  system clock (500 Hz divided clock); one clock domain only.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: pl  input  1  left-player pull pulse, from the upstream sync/one-pulse stage.
REQ-006 Port: pr  input  1  right-player pull pulse, from the upstream sync/one-pulse stage.
REQ-007 Port: slowen  input  1  single-cycle slow-tick enable (Div256 output).
REQ-008 Port: leds  output  7  rope display, consumed by the LED mux; bit 6 = leftmost.
REQ-009 Port: score_l, score_r  output  2 each  round wins per player.
REQ-010 Port: win_l, win_r  output  1 each  match-winner flags.
REQ-011 Port: round_done  output  1  single-cycle pulse when a round is won.
REQ-012 Port: tie  output  1  single-cycle pulse when pl and pr are high in the same cycle.

Function
REQ-013 States: PLAY, RWIN_L, RWIN_R, MATCH; the state register, pos[2:0], scores and all outputs are registered.
REQ-014 PLAY: leds = one-hot 1<<pos; pos ranges 0..6; centre = 3.
REQ-015 PLAY, pl=1 and pr=0, pos<6: pos+1 (moves left) on the next edge.
REQ-016 PLAY, pr=1 and pl=0, pos>0: pos-1 (moves right) on the next edge.
REQ-017 PLAY, pl=1 and pr=1: pos unchanged; tie=1 for exactly that one following cycle.
REQ-018 PLAY, pl=1 at pos=6: score_l+1 and enter RWIN_L; round_done=1 for one cycle.
REQ-019 PLAY, pr=1 at pos=0: score_r+1 and enter RWIN_R; round_done=1 for one cycle.
REQ-020 A pulse that stays high for N cycles counts as N pulls; the block does no edge detection.
REQ-021 Output latency is one clk from the pull input to the leds, score, round_done and tie update.
REQ-022 RWIN_L: leds alternate 7'b1110000 / 7'b0000000, starting lit; the pattern toggles on each slowen cycle.
REQ-023 RWIN_R: same as RWIN_L, using the pattern 7'b0000111.
REQ-024 RWIN_x: pl and pr are ignored; no tie pulse is issued.
REQ-025 RWIN_x: a 4-bit tick counter counts slowen cycles.
REQ-026 RWIN_x exit: on the FLASH_TICKS-th slowen, go to MATCH if the winner's score equals WINS_TO_MATCH.
REQ-027 RWIN_x exit otherwise: go to PLAY with pos=3 and the tick counter cleared.
REQ-028 MATCH: leds are solid in the winner's pattern (1110000 left, 0000111 right).
REQ-029 MATCH: win_l or win_r is held high, all inputs are ignored, and the state is left only by rst.
REQ-030 Scores saturate at WINS_TO_MATCH and never wrap.
REQ-031 The tick counter advances only on slowen; clk cycles without slowen hold it.
REQ-032 slowen coincident with a pull in PLAY has no effect on the pull.

Reset
REQ-033 rst=1 at a clk edge: state=PLAY, pos=3, leds=7'b0001000.
REQ-034 rst=1 at a clk edge: score_l=score_r=0, win_l=win_r=0, round_done=0, tie=0, tick counter=0.
REQ-035 rst has priority over every input and state, including mid-flash and MATCH.
REQ-036 After rst is released, the first pull is accepted on the first edge where rst=0.

Verification
REQ-037 Reset, then 3 single pl pulses: leds go 0001000 -> 0010000 -> 0100000 -> 1000000, one cycle after each pulse.
REQ-038 From pos=6, one pl: score_l=1, round_done one cycle, RWIN_L flash; after 8 slowen ticks leds=0001000, state PLAY.
REQ-039 pl and pr high in the same cycle at pos=3: leds stay 0001000, tie pulses once, scores unchanged.
REQ-040 Right wins two rounds (WINS_TO_MATCH=2): score_r=2, win_r=1, leds=0000111 solid; further pulls cause no change.
REQ-041 pl held for 4 cycles from centre: pos=6 after 3 cycles, round won on the 4th, score_l=1.
REQ-042 rst asserted during the RWIN_L flash and during MATCH: next cycle leds=0001000, all scores and flags 0.
